// File: rtl/pool_line_buffer.sv
// pool_line_buffer
//   Streaming window generator for the pooling stage. Pixels arrive in raster
//   order, one per cycle, with Pin channels packed side by side. The block
//   buffers Kh-1 complete rows and a Kh x Kw sliding window. At every
//   stride-aligned window position it emits the whole window together with a
//   one-cycle strobe. There is no backpressure.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   in_valid       pixel beat valid; when low, all state is frozen
//   in_data        pixel; channel g at [g*BIT_WIDTH +: BIT_WIDTH]
//   pool_array_en  one-cycle strobe, one cycle after the beat that completes a window
//   pool_data      window; channel g, element i=r*Kw+c at
//                  [(g*Kh*Kw+i)*BIT_WIDTH +: BIT_WIDTH]. r=0 is the oldest row,
//                  c=0 is the oldest column. Held between strobes.
//   frame_done     one-cycle pulse after the last pixel of a frame is accepted
module pool_line_buffer #(
    parameter int Kh        = 3,
    parameter int Kw        = 3,
    parameter int Pin       = 2,
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int STRIDE    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [Pin*BIT_WIDTH-1:0]        in_data,
    output logic                            pool_array_en,
    output logic [Pin*Kh*Kw*BIT_WIDTH-1:0]  pool_data,
    output logic                            frame_done
);

    localparam int DW  = Pin * BIT_WIDTH;
    localparam int PDW = Pin * Kh * Kw * BIT_WIDTH;
    localparam int CW  = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
    localparam int RW  = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
    localparam int PW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(Kw - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(Kh - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    // Stride phases. Each phase is 0 at the first position that can complete a
    // window, and it advances modulo STRIDE from there. Each phase is forced
    // to 0 before that position, so no divider is needed.
    logic [PW-1:0] col_ph;
    logic [PW-1:0] row_ph;

    logic col_end;
    logic row_end;
    logic win_ok;

    logic [Kh-1:0][DW-1:0]         column;   // r=0 oldest row, r=Kh-1 = in_data
    logic [Kh-1:0][Kw-1:0][DW-1:0] win;
    logic [Kh-1:0][Kw-1:0][DW-1:0] win_nxt;
    logic [PDW-1:0]                pd_nxt;

    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);
    // Row and column gating alone keep windows from straddling a row wrap or
    // a frame boundary. Stale buffer contents therefore never reach the output.
    assign win_ok  = (row >= ROW_FIRST) && (col >= COL_FIRST) &&
                     (row_ph == '0) && (col_ph == '0);

    // ------------------------------------------------------------------
    // Position and stride-phase counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (in_valid) begin
            if (col_end) begin
                col    <= '0;
                col_ph <= '0;
                if (row_end) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row    <= row + RW'(1);
                    if (row >= ROW_FIRST)
                        row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + PW'(1);
                    else
                        row_ph <= '0;
                end
            end else begin
                col <= col + CW'(1);
                if (col >= COL_FIRST)
                    col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + PW'(1);
                else
                    col_ph <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row buffers: Kh-1 rows, indexed by column. Reading at col gives the
    // pixels directly above the incoming one, so the buffers plus in_data
    // form one Kh-tall column. On write, each row moves up by one at col.
    // ------------------------------------------------------------------
    generate
        if (Kh > 1) begin : g_rows
            logic [DW-1:0] rb [Kh-1][IMG_W];

            always_comb begin
                column = '0;
                for (int k = 0; k < Kh - 1; k++)
                    column[k] = rb[k][col];
                column[Kh-1] = in_data;
            end

            always_ff @(posedge clk) begin
                if (in_valid) begin
                    for (int k = 0; k < Kh - 2; k++)
                        rb[k][col] <= rb[k+1][col];
                    rb[Kh-2][col] <= in_data;
                end
            end
        end else begin : g_norows
            assign column = in_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window shift. The new column enters at c=Kw-1 and older columns move
    // toward c=0. The output is taken from win_nxt so that the strobe
    // carries the window that includes the completing pixel.
    // ------------------------------------------------------------------
    generate
        for (genvar gr = 0; gr < Kh; gr++) begin : g_wr
            for (genvar gc = 0; gc < Kw; gc++) begin : g_wc
                if (gc < Kw - 1) begin : g_shift
                    assign win_nxt[gr][gc] = win[gr][gc+1];
                end else begin : g_load
                    assign win_nxt[gr][gc] = column[gr];
                end
                for (genvar gg = 0; gg < Pin; gg++) begin : g_ch
                    assign pd_nxt[((gg*Kh + gr)*Kw + gc)*BIT_WIDTH +: BIT_WIDTH] =
                        win_nxt[gr][gc][gg*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win           <= '0;
            pool_data     <= '0;
            pool_array_en <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            pool_array_en <= in_valid && win_ok;
            frame_done    <= in_valid && col_end && row_end;
            if (in_valid) begin
                win <= win_nxt;
                if (win_ok)
                    pool_data <= pd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pool_line_buffer.sv
module tb_pool_line_buffer;
    localparam int W = 16, H = 16, KH = 3, KW = 3, P = 2, BW = 8;
    localparam int DW = P * BW, PDW = P * KH * KW * BW;

    logic           clk = 1'b0;
    logic           rst, in_valid;
    logic [DW-1:0]  in_data;
    logic           en2, fd2, en1, fd1;
    logic [PDW-1:0] pd2, pd1;

    always #5 clk = ~clk;

    pool_line_buffer #(.Kh(KH), .Kw(KW), .Pin(P), .BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H), .STRIDE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .pool_array_en(en2), .pool_data(pd2), .frame_done(fd2));

    pool_line_buffer #(.Kh(KH), .Kw(KW), .Pin(P), .BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .pool_array_en(en1), .pool_data(pd1), .frame_done(fd1));

    int checks = 0, errors = 0;

    // Reference model: the current frame image plus the expected outputs.
    logic [DW-1:0]  fr [H][W];
    int             n;
    logic           exp_en2, exp_en1, exp_fd;
    logic [PDW-1:0] exp_pd2, exp_pd1;

    // Per-frame statistics observed from the DUTs.
    int             cnt2, cnt1, fd_cnt, first_beat2, first_beat1, prev1, gap1_err;
    logic [PDW-1:0] first_pd2, last_pd2, last_pd1;

    function automatic bit wvalid(int r, int c, int s);
        return r >= KH-1 && c >= KW-1 && (r-KH+1) % s == 0 && (c-KW+1) % s == 0;
    endfunction

    function automatic logic [PDW-1:0] win_of(int r, int c);
        logic [PDW-1:0] v = '0;
        logic [DW-1:0]  p;
        for (int rr = 0; rr < KH; rr++)
            for (int cc = 0; cc < KW; cc++) begin
                p = fr[r-KH+1+rr][c-KW+1+cc];
                for (int g = 0; g < P; g++)
                    v[(g*KH*KW + rr*KW + cc)*BW +: BW] = p[g*BW +: BW];
            end
        return v;
    endfunction

    function automatic logic [DW-1:0] pix(int r, int c, int off);
        logic [7:0] a = 8'((r*16 + c + off) % 256);
        return {8'(255 - int'(a)), a};
    endfunction

    function automatic int elem(logic [PDW-1:0] v, int g, int i);
        return int'(v[(g*KH*KW + i)*BW +: BW]);
    endfunction

    task automatic model_reset();
        n = 0; exp_en2 = 0; exp_en1 = 0; exp_fd = 0; exp_pd2 = '0; exp_pd1 = '0;
    endtask

    task automatic beat(input bit v, input logic [DW-1:0] d);
        int r, c;
        @(negedge clk);
        in_valid = v; in_data = d;
        @(posedge clk);
        #1;
        exp_en2 = 0; exp_en1 = 0; exp_fd = 0;
        if (v) begin
            r = n / W; c = n % W;
            fr[r][c] = d;
            exp_en2 = wvalid(r, c, 2);
            exp_en1 = wvalid(r, c, 1);
            if (exp_en2) exp_pd2 = win_of(r, c);
            if (exp_en1) exp_pd1 = win_of(r, c);
            exp_fd = (n == W*H - 1);
            n = (n + 1) % (W*H);
        end
    endtask

    // Feeds nb pixels of a frame with pixel offset off. Each cycle carries a
    // valid beat with probability duty percent; idle cycles carry random data.
    task automatic run_frame(input int off, input int duty, input int nb);
        int k = 0;
        bit v;
        cnt2 = 0; cnt1 = 0; fd_cnt = 0; first_beat2 = -1; first_beat1 = -1;
        prev1 = -100; gap1_err = 0;
        while (k < nb) begin
            v = ($urandom_range(99) < duty);
            if (v) beat(1'b1, pix(k / W, k % W, off));
            else   beat(1'b0, DW'($urandom));
            checks++; if (en2 !== exp_en2) begin errors++; $display("FAIL en2 k=%0d got %b want %b", k, en2, exp_en2); end
            checks++; if (pd2 !== exp_pd2) begin errors++; $display("FAIL pd2 k=%0d got %h want %h", k, pd2, exp_pd2); end
            checks++; if (en1 !== exp_en1) begin errors++; $display("FAIL en1 k=%0d got %b want %b", k, en1, exp_en1); end
            checks++; if (pd1 !== exp_pd1) begin errors++; $display("FAIL pd1 k=%0d got %h want %h", k, pd1, exp_pd1); end
            checks++; if (fd2 !== exp_fd || fd1 !== exp_fd) begin
                errors++; $display("FAIL frame_done k=%0d got %b/%b want %b", k, fd2, fd1, exp_fd);
            end
            if (en2 === 1'b1) begin
                if (cnt2 == 0) begin first_beat2 = k; first_pd2 = pd2; end
                last_pd2 = pd2; cnt2++;
            end
            if (en1 === 1'b1) begin
                if (cnt1 == 0) first_beat1 = k;
                else if (prev1 / W == k / W && k - prev1 != 1) gap1_err++;
                prev1 = k; last_pd1 = pd1; cnt1++;
            end
            if (fd2 === 1'b1) fd_cnt++;
            if (v) k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = i[0]; in_data = DW'($urandom);
            @(posedge clk);
            #1;
            checks++; if ({en2, fd2, en1, fd1, pd2, pd1} !== '0) begin
                errors++; $display("FAIL reset_hold cyc=%0d got en=%b fd=%b pd=%h want 0", i, en2, fd2, pd2);
            end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({en2, fd2, en1, fd1, pd2, pd1} !== '0) begin
            errors++; $display("FAIL reset_release got en=%b fd=%b pd=%h want 0", en2, fd2, pd2);
        end
    endtask

    task automatic test_single_frame();
        run_frame(0, 100, W*H);
        checks++; if (cnt2 != 49) begin errors++; $display("FAIL frame_strobes got %0d want 49", cnt2); end
        checks++; if (first_beat2 != 34) begin errors++; $display("FAIL first_beat got %0d want 34", first_beat2); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (elem(first_pd2, 0, i) != (i/3)*16 + i%3 || elem(first_pd2, 1, i) != 255 - ((i/3)*16 + i%3)) begin
                errors++; $display("FAIL first_win i=%0d got %0d/%0d want %0d", i,
                                   elem(first_pd2, 0, i), elem(first_pd2, 1, i), (i/3)*16 + i%3);
            end
        end
        checks++; if (elem(last_pd2, 0, 0) != 204 || elem(last_pd2, 0, 8) != 238) begin
            errors++; $display("FAIL last_win got %0d..%0d want 204..238", elem(last_pd2, 0, 0), elem(last_pd2, 0, 8));
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
    endtask

    task automatic test_random_valid();
        run_frame(0, 50, W*H);
        checks++; if (cnt2 != 49 || cnt1 != 196) begin
            errors++; $display("FAIL gapped_strobes got %0d/%0d want 49/196", cnt2, cnt1);
        end
    endtask

    task automatic test_back_to_back();
        int total;
        run_frame(0, 100, W*H);
        total = cnt2;
        run_frame(100, 100, W*H);
        total += cnt2;
        checks++; if (total != 98) begin errors++; $display("FAIL b2b_strobes got %0d want 98", total); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (elem(first_pd2, 0, i) != 100 + (i/3)*16 + i%3) begin
                errors++; $display("FAIL b2b_first_win i=%0d got %0d want %0d", i, elem(first_pd2, 0, i), 100 + (i/3)*16 + i%3);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_frame(0, 100, 101);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({en2, fd2, en1, fd1, pd2, pd1} !== '0) begin
            errors++; $display("FAIL async_reset got en=%b pd=%h want 0", en2, pd2);
        end
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, 100, W*H);
        checks++; if (cnt2 != 49 || first_beat2 != 34) begin
            errors++; $display("FAIL post_reset got strobes=%0d first=%0d want 49/34", cnt2, first_beat2);
        end
        checks++; if (elem(first_pd2, 0, 0) != 0 || elem(first_pd2, 0, 4) != 17 || elem(first_pd2, 0, 8) != 34) begin
            errors++; $display("FAIL post_reset_win got %0d/%0d/%0d want 0/17/34",
                               elem(first_pd2, 0, 0), elem(first_pd2, 0, 4), elem(first_pd2, 0, 8));
        end
    endtask

    task automatic test_stride1();
        run_frame(0, 100, W*H);
        checks++; if (cnt1 != 196) begin errors++; $display("FAIL s1_strobes got %0d want 196", cnt1); end
        checks++; if (first_beat1 != 34) begin errors++; $display("FAIL s1_first_beat got %0d want 34", first_beat1); end
        checks++; if (gap1_err != 0) begin errors++; $display("FAIL s1_consecutive got %0d gaps want 0", gap1_err); end
        checks++; if (elem(last_pd1, 0, 0) != 221 || elem(last_pd1, 1, 8) != 255 - 255) begin
            errors++; $display("FAIL s1_last_win got %0d want 221", elem(last_pd1, 0, 0));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        model_reset();
        test_reset();
        test_single_frame();
        test_random_valid();
        test_back_to_back();
        test_reset_mid();
        test_stride1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
